// File: rtl/hdma_xfer.sv
// HDMA/GDMA byte mover: one bus read then one VRAM write per engine address pair, plus CPU stall.
// Optional HDMA_XFER_STATS_EN adds byte_count / drop_count transfer statistics outputs.
module hdma_xfer #(
    parameter logic [7:0] FF_FILL = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        hdma_active,
    input  logic        hdma_rd,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [1:0]  lcd_mode,
    input  logic [7:0]  bus_din,
    output logic        bus_rd,
    output logic [15:0] bus_addr,
    output logic        vram_we,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_dout,
    output logic        cpu_stall,
    output logic        xfer_dropped
`ifdef HDMA_XFER_STATS_EN
    ,
    output logic [15:0] byte_count,
    output logic [7:0]  drop_count
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e      state_q, state_d;
    logic        rd_q;
    logic [15:0] last_src_q, last_src_d;
    logic [15:0] src_q, src_d;
    logic [12:0] dst_q, dst_d;
    logic [7:0]  data_q, data_d;
    logic        new_byte;
    logic        load;
    logic [15:0] src_remap;
    logic        vram_locked;
    logic        unused_dst_hi;

    // The engine keeps dst inside VRAM; only the 8 KiB offset matters here.
    assign unused_dst_hi = ^dst_addr[15:13];

    always_comb begin
        new_byte    = hdma_rd & (~rd_q | (src_addr != last_src_q));
        src_remap   = src_addr;
        // Echo RAM region E000-FFFF is fetched from A000-BFFF.
        if (src_addr[15:13] == 3'b111) begin
            src_remap[14] = 1'b0;
        end
        vram_locked = (lcd_mode == 2'd3);
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        last_src_d = last_src_q;
        data_d     = data_q;
        load       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (new_byte) begin
                    load    = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (!hdma_rd) begin
                    state_d = StIdle;
                end else begin
                    data_d  = (src_q[15:13] == 3'b100) ? FF_FILL : bus_din;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (new_byte) begin
                    load    = 1'b1;
                    state_d = StRead;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            src_d      = src_remap;
            dst_d      = dst_addr[12:0];
            last_src_d = src_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_q       <= 1'b0;
            last_src_q <= 16'h0000;
            src_q      <= 16'h0000;
            dst_q      <= 13'h0000;
            data_q     <= 8'h00;
        end else if (ce) begin
            state_q    <= state_d;
            rd_q       <= hdma_rd;
            last_src_q <= last_src_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            data_q     <= data_d;
        end
    end

    assign bus_rd       = (state_q == StRead);
    assign bus_addr     = src_q;
    assign vram_we      = (state_q == StWrite) & ~vram_locked;
    assign xfer_dropped = (state_q == StWrite) & vram_locked;
    assign vram_addr    = dst_q;
    assign vram_dout    = data_q;
    assign cpu_stall    = hdma_active;

`ifdef HDMA_XFER_STATS_EN
    logic active_q;
    logic stats_clr;

    assign stats_clr = hdma_active & ~active_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= 1'b0;
            byte_count <= 16'h0000;
            drop_count <= 8'h00;
        end else if (ce) begin
            active_q <= hdma_active;
            if (stats_clr) begin
                byte_count <= 16'h0000;
                drop_count <= 8'h00;
            end else begin
                if (vram_we) begin
                    byte_count <= byte_count + 16'd1;
                end
                if (xfer_dropped && (drop_count != 8'hFF)) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_hdma_xfer.sv
// Randomized bench for hdma_xfer: per-byte engine timelines checked against a transfer-level model.
module tb_hdma_xfer;

    logic        clk = 1'b0;
    logic        reset, ce, hdma_active, hdma_rd;
    logic [15:0] src_addr, dst_addr;
    logic [1:0]  lcd_mode;
    logic [7:0]  bus_din;
    logic        bus_rd, vram_we, cpu_stall, xfer_dropped;
    logic [15:0] bus_addr;
    logic [12:0] vram_addr;
    logic [7:0]  vram_dout;
`ifdef HDMA_XFER_STATS_EN
    logic [15:0] byte_count;
    logic [7:0]  drop_count;
`endif

    always #5 clk = ~clk;

    hdma_xfer dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .hdma_active  (hdma_active),
        .hdma_rd      (hdma_rd),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .lcd_mode     (lcd_mode),
        .bus_din      (bus_din),
        .bus_rd       (bus_rd),
        .bus_addr     (bus_addr),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_dout    (vram_dout),
        .cpu_stall    (cpu_stall),
        .xfer_dropped (xfer_dropped)
`ifdef HDMA_XFER_STATS_EN
        ,
        .byte_count   (byte_count),
        .drop_count   (drop_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] mon_rd[$];
    logic [12:0] mon_wa[$];
    logic [7:0]  mon_wd[$];
    int          mon_drops = 0;
    logic [7:0]  junk;

    function automatic logic [7:0] bus_byte(input logic [15:0] a);
        logic [7:0] hi;
        hi = a[15:8];
        return a[7:0] ^ {hi[6:0], hi[7]} ^ 8'h5A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic ce_v);
        ce = ce_v;
        @(posedge clk);
        #1;
    endtask

    // Bus model: cart/WRAM bytes are a fixed function of the address; VRAM reads return noise.
    always_ff @(posedge clk) junk <= 8'($urandom);
    always_comb begin
        bus_din = junk;
        if (bus_rd && (bus_addr < 16'h8000 || bus_addr >= 16'hA000)) bus_din = bus_byte(bus_addr);
    end

    always @(negedge clk) begin
        if (!reset && ce) begin
            if (bus_rd) mon_rd.push_back(bus_addr);
            if (vram_we) begin
                mon_wa.push_back(vram_addr);
                mon_wd.push_back(vram_dout);
            end
            if (xfer_dropped) mon_drops++;
        end
    end

    // One engine burst of n bytes, slot ce per byte; lock_i / rdrop_i select a byte (>= n: none).
    task automatic run_block(input logic [15:0] src0, input int stride, input logic [15:0] dst0,
                             input int n, input int slot, input int lock_i, input int rdrop_i,
                             input bit gap_rd);
        logic [15:0] s_src[80];
        logic [15:0] s_dst[80];
        bit          s_rd[80];
        bit          s_act[80];
        logic [1:0]  s_mode[80];
        logic [15:0] exp_ra[$];
        logic [12:0] exp_wa[$];
        logic [7:0]  exp_wd[$];
        logic [15:0] src_i, dst_i, rmp;
        int exp_drops, total, rb, wb, db, nr, nw, t;
        exp_drops = 0;
        total = 1 + n * slot + 4;
        rb = mon_rd.size();
        wb = mon_wa.size();
        db = mon_drops;
        for (int s = 0; s < total; s++) begin
            s_src[s]  = src0;
            s_dst[s]  = dst0;
            s_rd[s]   = 1'b0;
            s_act[s]  = (s < total - 1);
            s_mode[s] = 2'd0;
        end
        for (int i = 0; i < n; i++) begin
            t     = 1 + i * slot;
            src_i = src0 + 16'(i * stride);
            dst_i = 16'h8000 | ((dst0 + 16'(i)) & 16'h1FFF);
            for (int k = 0; k < slot; k++) begin
                s_src[t + k] = src_i;
                s_dst[t + k] = dst_i;
                s_rd[t + k]  = !((i == rdrop_i && k >= 1) || (gap_rd && slot >= 3 && k == slot - 1));
            end
            if (i == lock_i) s_mode[t + 2] = 2'd3;
            rmp = (src_i >= 16'hE000) ? src_i - 16'h4000 : src_i;
            exp_ra.push_back(rmp);
            if (i == rdrop_i) continue;
            if (i == lock_i) begin
                exp_drops++;
            end else begin
                exp_wa.push_back(dst_i[12:0]);
                exp_wd.push_back((src_i >= 16'h8000 && src_i < 16'hA000) ? 8'hFF : bus_byte(rmp));
            end
        end

        for (int s = 0; s < total; s++) begin
            src_addr    = s_src[s];
            dst_addr    = s_dst[s];
            hdma_rd     = s_rd[s];
            hdma_active = s_act[s];
            lcd_mode    = s_mode[s];
            if (s == total / 2) repeat (10) tick(1'b0);
            else repeat ($urandom_range(0, 2)) tick(1'b0);
            tick(1'b1);
            if (s == 0) check_eq("stall_on", 32'(cpu_stall), 32'd1);
        end
        check_eq("stall_off", 32'(cpu_stall), 32'd0);

        nr = mon_rd.size() - rb;
        check_eq("n_reads", 32'(nr), 32'(exp_ra.size()));
        for (int i = 0; i < nr && i < exp_ra.size(); i++)
            check_eq("rd_addr", 32'(mon_rd[rb + i]), 32'(exp_ra[i]));
        nw = mon_wa.size() - wb;
        check_eq("n_writes", 32'(nw), 32'(exp_wa.size()));
        for (int i = 0; i < nw && i < exp_wa.size(); i++) begin
            check_eq("wr_addr", 32'(mon_wa[wb + i]), 32'(exp_wa[i]));
            check_eq("wr_data", 32'(mon_wd[wb + i]), 32'(exp_wd[i]));
        end
        check_eq("n_drops", 32'(mon_drops - db), 32'(exp_drops));
`ifdef HDMA_XFER_STATS_EN
        check_eq("byte_count", 32'(byte_count), 32'(exp_wa.size()));
        check_eq("drop_count", 32'(drop_count), 32'(exp_drops));
`endif
    endtask

    initial begin
        int wb;
        logic [15:0] bases[6];
        int n, slot, lk, rdp;
        bases = '{16'h0100, 16'h4321, 16'h9FF8, 16'hA800, 16'hC000, 16'hFFF4};

        reset = 1'b1; ce = 1'b0; hdma_active = 1'b0; hdma_rd = 1'b0;
        src_addr = 16'h0000; dst_addr = 16'h8000; lcd_mode = 2'd0;
        repeat (3) tick(1'b1);
        reset = 1'b0;
        check_eq("rst_bus_rd", 32'(bus_rd), 32'd0);
        check_eq("rst_vram_we", 32'(vram_we), 32'd0);
        check_eq("rst_dropped", 32'(xfer_dropped), 32'd0);
        check_eq("rst_bus_addr", 32'(bus_addr), 32'd0);
        check_eq("rst_vram_addr", 32'(vram_addr), 32'd0);
        check_eq("rst_vram_dout", 32'(vram_dout), 32'd0);
        check_eq("rst_stall", 32'(cpu_stall), 32'd0);
`ifdef HDMA_XFER_STATS_EN
        check_eq("rst_byte_count", 32'(byte_count), 32'd0);
        check_eq("rst_drop_count", 32'(drop_count), 32'd0);
`endif

        run_block(16'hC000, 1, 16'h8200, 16, 2, 99, 99, 1'b0);
        run_block(16'hC000, 1, 16'h8200, 16, 4, 99, 99, 1'b0);
        run_block(16'hE010, 1, 16'h8000, 4, 2, 99, 99, 1'b0);
        run_block(16'h8800, 1, 16'h9000, 4, 3, 99, 99, 1'b0);
        run_block(16'hC000, 1, 16'h8200, 16, 2, 2, 99, 1'b0);
        run_block(16'hC000, 1, 16'h8200, 16, 2, 99, 4, 1'b0);
        run_block(16'hD000, 0, 16'h9FFE, 4, 4, 99, 99, 1'b1);

        // Reset while the WRITE strobe is up must kill the write outright.
        wb = mon_wa.size();
        hdma_active = 1'b1; hdma_rd = 1'b1; src_addr = 16'hC123; dst_addr = 16'h8456;
        tick(1'b1);
        tick(1'b1);
        check_eq("pre_rst_we", 32'(vram_we), 32'd1);
        check_eq("pre_rst_addr", 32'(vram_addr), 32'h456);
        reset = 1'b1;
        tick(1'b1);
        check_eq("mid_rst_we", 32'(vram_we), 32'd0);
        check_eq("mid_rst_bus_rd", 32'(bus_rd), 32'd0);
        check_eq("mid_rst_vaddr", 32'(vram_addr), 32'd0);
        check_eq("mid_rst_vdout", 32'(vram_dout), 32'd0);
        check_eq("mid_rst_baddr", 32'(bus_addr), 32'd0);
        reset = 1'b0; hdma_rd = 1'b0; hdma_active = 1'b0;
        repeat (3) tick(1'b1);
        check_eq("mid_rst_nowrite", 32'(mon_wa.size() - wb), 32'd0);

        for (int r = 0; r < 8; r++) begin
            n    = $urandom_range(4, 16);
            slot = $urandom_range(2, 4);
            lk   = $urandom_range(0, n);
            rdp  = $urandom_range(0, n);
            if (rdp == lk) rdp = n;
            run_block(bases[$urandom_range(0, 5)] + 16'($urandom_range(0, 7)), 1,
                      16'h8000 | 16'($urandom_range(0, 16'h1FFF)), n, slot, lk, rdp,
                      1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
